// File: rtl/logic_gate_pipe.sv
// Bitwise gate unit (NOT/AND/NAND/OR/NOR/XOR/XNOR) behind a 2-entry in-order result buffer.
// Define LOGIC_GATE_PIPE_STATS_EN to build the saturating ops_count transfer counter.
module logic_gate_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             op_err,
    output logic [15:0]      ops_count
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             err;
    } entry_t;

    entry_t     head_q, head_d, tail_q, tail_d, new_e;
    logic [1:0] cnt_q, cnt_d;
    logic       in_ready_q, out_valid_q;
    logic       push, pop;

    always_comb begin
        new_e.err = 1'b0;
        unique case (op)
            3'd0:    new_e.res = ~in_a;
            3'd1:    new_e.res = in_a & in_b;
            3'd2:    new_e.res = ~(in_a & in_b);
            3'd3:    new_e.res = in_a | in_b;
            3'd4:    new_e.res = ~(in_a | in_b);
            3'd5:    new_e.res = in_a ^ in_b;
            3'd6:    new_e.res = ~(in_a ^ in_b);
            default: begin
                new_e.res = '0;
                new_e.err = 1'b1;
            end
        endcase
    end

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // Head always holds the oldest entry; tail only matters at occupancy 2.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = new_e;
                else               tail_d = new_e;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: head_d = new_e;
            default: ;
        endcase
    end

    // Handshake flags are registered from next occupancy so neither depends
    // combinationally on in_valid or out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= 2'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (cnt_d != 2'd2);
            out_valid_q <= (cnt_d != 2'd0);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = head_q.res;
    assign op_err    = head_q.err;

`ifdef LOGIC_GATE_PIPE_STATS_EN
    logic [15:0] ops_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           ops_q <= 16'h0000;
        else if (pop && ops_q != 16'hFFFF) ops_q <= ops_q + 16'd1;
    end

    assign ops_count = ops_q;
`else
    assign ops_count = 16'h0000;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: truth table, backpressure, push/pop, reset, counter.
module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, op_err;
    logic [2:0] op;
    logic [7:0] in_a, in_b, result;
    logic [15:0] ops_count;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    logic [15:0] exp_cnt;

    logic [7:0] tt_exp [8] = '{8'h0F, 8'hC0, 8'h3F, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h00};

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .op_err(op_err), .ops_count(ops_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string name);
`ifdef LOGIC_GATE_PIPE_STATS_EN
        exp_cnt = (xfers > 65535) ? 16'hFFFF : 16'(xfers);
`else
        exp_cnt = 16'h0000;
`endif
        checks++;
        if (ops_count !== exp_cnt) begin
            errors++;
            $display("FAIL %s: ops_count got %h want %h", name, ops_count, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; in_a = '0; in_b = '0;
        #2;
        checks++;
        if ({out_valid, in_ready, op_err, result} !== 11'h0) begin
            errors++;
            $display("FAIL reset_async: ov=%b ir=%b err=%b res=%h want all 0",
                     out_valid, in_ready, op_err, result);
        end
        check_count("reset_count");
        step(); step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_hold_ready: got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL release_ready_pre: got %b want 0", in_ready);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL release_ready: ir=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_truth_table();
        out_ready = 1'b1; in_a = 8'hF0; in_b = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; op = 3'(i);
            step();
            if (i > 0) xfers++;
            checks++;
            if (out_valid !== 1'b1 || result !== tt_exp[i] || op_err !== (i == 7)) begin
                errors++;
                $display("FAIL truth_op%0d: ov=%b res=%h err=%b want 1 %h %b",
                         i, out_valid, result, op_err, tt_exp[i], (i == 7));
            end
        end
        in_valid = 1'b0;
        step();
        xfers++;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL truth_drain: ov=%b want 0", out_valid);
        end
        check_count("truth_count");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd1; in_a = 8'hFF; in_b = 8'h0F;
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h0F || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_first: ov=%b res=%h ir=%b want 1 0f 1", out_valid, result, in_ready);
        end
        op = 3'd3; in_a = 8'h00; in_b = 8'h55;
        step();
        checks++;
        if (in_ready !== 1'b0 || result !== 8'h0F) begin
            errors++; $display("FAIL bp_full: ir=%b res=%h want 0 0f", in_ready, result);
        end
        op = 3'd5; in_a = 8'hAA; in_b = 8'h11;
        step(); step();
        checks++;
        if (in_ready !== 1'b0 || result !== 8'h0F || op_err !== 1'b0) begin
            errors++; $display("FAIL bp_hold: ir=%b res=%h err=%b want 0 0f 0", in_ready, result, op_err);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        xfers++;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h55 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_second: ov=%b res=%h ir=%b want 1 55 1", out_valid, result, in_ready);
        end
        step();
        xfers++;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        check_count("bp_count");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; in_a = 8'h00; in_b = 8'h00;
        step();
        checks++;
        if (result !== 8'hFF || out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_prime: res=%h ov=%b want ff 1", result, out_valid);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            op = 3'd1; in_a = 8'(8'h11 * k); in_b = 8'hFF;
            step();
            xfers++;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== 8'(8'h11 * k)) begin
                errors++;
                $display("FAIL b2b_%0d: ov=%b ir=%b res=%h want 1 1 %h",
                         k, out_valid, in_ready, result, 8'(8'h11 * k));
            end
        end
        in_valid = 1'b0;
        step();
        xfers++;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: ov=%b want 0", out_valid);
        end
        check_count("b2b_count");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd6; in_a = 8'h5A; in_b = 8'h0F;
        step(); step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || result !== 8'hAA) begin
            errors++; $display("FAIL mid_full: ir=%b res=%h want 0 aa", in_ready, result);
        end
        #2 rst = 1'b1;
        #1;
        xfers = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 8'h00) begin
            errors++; $display("FAIL mid_async: ov=%b ir=%b res=%h want 0 0 00", out_valid, in_ready, result);
        end
        check_count("mid_count");
        step();
        rst = 1'b0; out_ready = 1'b1;
        step(); step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_stale: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_counter();
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd3; in_a = 8'h01; in_b = 8'h02;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i > 0) xfers++;
        end
        in_valid = 1'b0;
        step();
        xfers++;
        check_count("count_10");
`ifdef LOGIC_GATE_PIPE_STATS_EN
        in_valid = 1'b1;
        for (int i = 0; i < 65540; i++) step();
        in_valid = 1'b0;
        step();
        xfers = xfers + 65540;
        check_count("count_sat");
`endif
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
